// File: rtl/power_pkg.sv
// Shared types and limits for the power domain hub and its timers.
package power_pkg;

  // Domain power phases; each one maps to exactly one child status line.
  typedef enum logic [1:0] {
    OFF      = 2'd0,
    STARTING = 2'd1,
    ON       = 2'd2,
    STOPPING = 2'd3
  } power_state_t;

  // Legal parameter ranges for the hub.
  localparam int unsigned N_CHILD_MIN       = 1;
  localparam int unsigned N_CHILD_MAX       = 32;
  localparam int unsigned SETTLE_CYCLES_MAX = 255;
  localparam int unsigned HOLD_CYCLES_MIN   = 1;
  localparam int unsigned HOLD_CYCLES_MAX   = 255;

  // Bits needed to hold 0..max_value; at least one bit so a zero limit still elaborates.
  function automatic int unsigned counter_width(input int unsigned max_value);
    return (max_value == 0) ? 1 : $clog2(max_value + 1);
  endfunction

endpackage

// File: rtl/power_hold_timer.sv
// Settle/idle timer: counts toward a fixed limit and flags the edge on which it gets there.
// Down mode loads the limit once and counts to zero; up mode counts from zero to the limit.
module power_hold_timer
  import power_pkg::*;
#(
  parameter int unsigned LIMIT_VALUE = 3,
  parameter bit          COUNT_UP    = 1'b0
) (
  input  logic clock,
  input  logic async_resetn,
  input  logic clear,
  input  logic load,
  input  logic step,
  output logic done
);

  localparam int unsigned       WIDTH  = counter_width(LIMIT_VALUE);
  localparam logic [WIDTH-1:0]  LIMIT  = WIDTH'(LIMIT_VALUE);
  localparam logic [WIDTH-1:0]  TARGET = COUNT_UP ? LIMIT : '0;

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             moved;

  // Next count: clear wins, a down counter loads only while idle at zero, and the
  // count never steps past its target so it cannot wrap.
  always_comb begin
    count_d = count_q;
    moved   = 1'b0;
    if (clear) begin
      count_d = '0;
    end else if (!COUNT_UP && load && (count_q == '0)) begin
      count_d = LIMIT;
      moved   = 1'b1;
    end else if (step && (count_q != TARGET)) begin
      count_d = COUNT_UP ? count_q + 1'b1 : count_q - 1'b1;
      moved   = 1'b1;
    end
  end

  assign done = moved && (count_d == TARGET);

  // Count register.
  always_ff @(posedge clock or negedge async_resetn) begin
    if (!async_resetn) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/power_domain_hub.sv
// Power domain hub: merges child power requests, sequences the supply switch and
// broadcasts a registered one-hot status to all children.
module power_domain_hub
  import power_pkg::*;
#(
  parameter int unsigned N_CHILD       = 4,
  parameter int unsigned SETTLE_CYCLES = 3,
  parameter int unsigned HOLD_CYCLES   = 5
) (
  input  logic               clock,
  input  logic               async_resetn,
  input  logic [N_CHILD-1:0] child_request,
  output logic               child_ready,
  output logic               child_silent,
  output logic               child_starting,
  output logic               child_stopping,
  output logic               supply_enb,
  input  logic               supply_ack
);

  // Out-of-range timings saturate at the nearest legal value.
  localparam int unsigned SETTLE_LIMIT =
    (SETTLE_CYCLES > SETTLE_CYCLES_MAX) ? SETTLE_CYCLES_MAX : SETTLE_CYCLES;
  localparam int unsigned HOLD_LIMIT =
    (HOLD_CYCLES < HOLD_CYCLES_MIN) ? HOLD_CYCLES_MIN :
    (HOLD_CYCLES > HOLD_CYCLES_MAX) ? HOLD_CYCLES_MAX : HOLD_CYCLES;

  power_state_t state_q;
  power_state_t state_d;
  logic         any_request;
  logic         settle_clear;
  logic         settle_done;
  logic         idle_clear;
  logic         idle_done;

  assign any_request = |child_request;

  // Settle timer only runs in STARTING; it arms on the first sampled ack and then
  // counts down every edge whatever the ack does.
  assign settle_clear = (state_q != STARTING);

  power_hold_timer #(
    .LIMIT_VALUE (SETTLE_LIMIT),
    .COUNT_UP    (1'b0)
  ) u_settle_timer (
    .clock        (clock),
    .async_resetn (async_resetn),
    .clear        (settle_clear),
    .load         (supply_ack),
    .step         (1'b1),
    .done         (settle_done)
  );

  // Idle timer only runs in ON and restarts from zero on any request.
  assign idle_clear = (state_q != ON) || any_request;

  power_hold_timer #(
    .LIMIT_VALUE (HOLD_LIMIT),
    .COUNT_UP    (1'b1)
  ) u_idle_timer (
    .clock        (clock),
    .async_resetn (async_resetn),
    .clear        (idle_clear),
    .load         (1'b0),
    .step         (1'b1),
    .done         (idle_done)
  );

  // Next-state rules; STARTING never aborts and STOPPING ignores requests.
  always_comb begin
    state_d = state_q;
    case (state_q)
      OFF:      if (any_request) state_d = STARTING;
      STARTING: if (settle_done) state_d = ON;
      ON:       if (idle_done)   state_d = STOPPING;
      STOPPING: if (!supply_ack) state_d = OFF;
      default:  state_d = OFF;
    endcase
  end

  // State register.
  always_ff @(posedge clock or negedge async_resetn) begin
    if (!async_resetn) begin
      state_q <= OFF;
    end else begin
      state_q <= state_d;
    end
  end

  // Outputs are registered from the next state so they line up with state_q
  // without any input-to-output combinational path.
  always_ff @(posedge clock or negedge async_resetn) begin
    if (!async_resetn) begin
      child_silent   <= 1'b1;
      child_starting <= 1'b0;
      child_ready    <= 1'b0;
      child_stopping <= 1'b0;
      supply_enb     <= 1'b0;
    end else begin
      child_silent   <= (state_d == OFF);
      child_starting <= (state_d == STARTING);
      child_ready    <= (state_d == ON);
      child_stopping <= (state_d == STOPPING);
      supply_enb     <= (state_d == STARTING) || (state_d == ON);
    end
  end

endmodule

// File: tb/tb_power_domain_hub.sv
// Self-checking bench for power_domain_hub (N_CHILD=4, SETTLE_CYCLES=3, HOLD_CYCLES=5).
module tb_power_domain_hub;

  localparam int N_CHILD = 4;
  localparam int SETTLE  = 3;
  localparam int HOLD    = 5;

  localparam int PH_OFF   = 0;
  localparam int PH_START = 1;
  localparam int PH_ON    = 2;
  localparam int PH_STOP  = 3;

  // Status vector order: {silent, starting, ready, stopping, supply_enb}
  localparam logic [4:0] S_OFF   = 5'b10000;
  localparam logic [4:0] S_START = 5'b01001;
  localparam logic [4:0] S_ON    = 5'b00101;
  localparam logic [4:0] S_STOP  = 5'b00010;

  logic               clock;
  logic               async_resetn;
  logic [N_CHILD-1:0] child_request;
  logic               child_ready;
  logic               child_silent;
  logic               child_starting;
  logic               child_stopping;
  logic               supply_enb;
  logic               supply_ack;

  int checks = 0;
  int errors = 0;

  power_domain_hub #(
    .N_CHILD       (N_CHILD),
    .SETTLE_CYCLES (SETTLE),
    .HOLD_CYCLES   (HOLD)
  ) dut (
    .clock          (clock),
    .async_resetn   (async_resetn),
    .child_request  (child_request),
    .child_ready    (child_ready),
    .child_silent   (child_silent),
    .child_starting (child_starting),
    .child_stopping (child_stopping),
    .supply_enb     (supply_enb),
    .supply_ack     (supply_ack)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Behavioural model: phase plus edge timestamps. ON begins SETTLE edges after the
  // first ack seen while starting; STOPPING begins once HOLD edges have passed since
  // the last busy edge (or ON entry).
  int m_phase     = PH_OFF;
  int m_edge      = 0;
  int m_ack_edge  = -1;
  int m_busy_edge = 0;

  always @(posedge clock or negedge async_resetn) begin
    if (!async_resetn) begin
      m_phase    = PH_OFF;
      m_ack_edge = -1;
    end else begin
      m_edge = m_edge + 1;
      case (m_phase)
        PH_OFF: begin
          if (child_request != '0) begin
            m_phase    = PH_START;
            m_ack_edge = -1;
          end
        end
        PH_START: begin
          if (m_ack_edge < 0 && supply_ack) m_ack_edge = m_edge;
          if (m_ack_edge >= 0 && (m_edge - m_ack_edge) == SETTLE) begin
            m_phase     = PH_ON;
            m_busy_edge = m_edge;
          end
        end
        PH_ON: begin
          if (child_request != '0) m_busy_edge = m_edge;
          else if ((m_edge - m_busy_edge) == HOLD) m_phase = PH_STOP;
        end
        PH_STOP: begin
          if (!supply_ack) m_phase = PH_OFF;
        end
        default: m_phase = PH_OFF;
      endcase
    end
  end

  function automatic logic [4:0] expectedOutputs(input int phase);
    case (phase)
      PH_START: return S_START;
      PH_ON:    return S_ON;
      PH_STOP:  return S_STOP;
      default:  return S_OFF;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [4:0] expected);
    logic [4:0] actual;
    actual = {child_silent, child_starting, child_ready, child_stopping, supply_enb};
    checks = checks + 1;
    if (actual !== expected) begin
      errors = errors + 1;
      $display("[TB] FAIL %s: got %b required %b at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic checkValue(input string name, input int actual, input int expected);
    checks = checks + 1;
    if (actual != expected) begin
      errors = errors + 1;
      $display("[TB] FAIL %s: got %0d required %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [N_CHILD-1:0] req, input logic ack);
    child_request = req;
    supply_ack    = ack;
  endtask

  // Every cycle: DUT status against the model, 1 time unit after the edge.
  always @(posedge clock) begin
    #1;
    checkOutput("model_cycle", expectedOutputs(m_phase));
  end

  // Directed sequence. "Nk" = the falling edge after rising edge k; inputs set at Nk
  // are sampled at edge k+1.
  initial begin
    async_resetn = 1'b0;
    applyStimulus(4'b1111, 1'b0);
    repeat (3) @(negedge clock);
    checkOutput("reset_hold", S_OFF);
    async_resetn = 1'b1;
    @(negedge clock);
    checkOutput("release_start", S_START);

    applyStimulus(4'b0000, 1'b0);
    #2 async_resetn = 1'b0;
    #1 checkOutput("async_off", S_OFF);
    @(negedge clock);
    async_resetn = 1'b1;
    @(negedge clock);
    checkOutput("idle_off", S_OFF);

    // Request sampled at edge 0, ack first sampled at edge 4.
    applyStimulus(4'b0001, 1'b0);
    @(negedge clock);
    checkOutput("req_start", S_START);
    repeat (3) @(negedge clock);
    applyStimulus(4'b0001, 1'b1);
    repeat (3) @(negedge clock);
    checkOutput("settle_last", S_START);
    @(negedge clock);
    checkOutput("settle_done", S_ON);

    // Ack glitch while ON is ignored.
    @(negedge clock);
    applyStimulus(4'b0001, 1'b0);
    @(negedge clock);
    checkOutput("ack_drop_on", S_ON);
    applyStimulus(4'b0001, 1'b1);

    // Idle at edges 11-13, busy at 14, idle 15-19.
    @(negedge clock);
    applyStimulus(4'b0000, 1'b1);
    repeat (3) @(negedge clock);
    applyStimulus(4'b0100, 1'b1);
    @(negedge clock);
    applyStimulus(4'b0000, 1'b1);
    repeat (4) @(negedge clock);
    checkOutput("hold_last_on", S_ON);
    @(negedge clock);
    checkOutput("hold_stop", S_STOP);

    // Requests ignored while stopping; ack low sampled at edge 22.
    applyStimulus(4'b1111, 1'b1);
    repeat (2) @(negedge clock);
    checkOutput("stop_wait", S_STOP);
    applyStimulus(4'b1111, 1'b0);
    @(negedge clock);
    checkOutput("off_one_cycle", S_OFF);
    @(negedge clock);
    checkOutput("restart", S_START);

    // Reset mid-settle with the settle count at 2.
    applyStimulus(4'b1111, 1'b1);
    repeat (2) @(negedge clock);
    checkValue("settle_count_mid", int'(dut.u_settle_timer.count_q), 2);
    #2 async_resetn = 1'b0;
    #1 checkOutput("mid_settle_reset", S_OFF);
    checkValue("settle_count_reset", int'(dut.u_settle_timer.count_q), 0);
    @(negedge clock);
    async_resetn = 1'b1;
    @(negedge clock);
    checkOutput("post_reset_start", S_START);
    repeat (3) @(negedge clock);
    checkOutput("restart_settle", S_START);
    @(negedge clock);
    checkOutput("restart_on", S_ON);

    // Drain to OFF.
    applyStimulus(4'b0000, 1'b1);
    repeat (5) @(negedge clock);
    checkOutput("drain_stop", S_STOP);
    applyStimulus(4'b0000, 1'b0);
    @(negedge clock);
    checkOutput("drain_off", S_OFF);

    // One-cycle request pulse in OFF runs the full cycle.
    applyStimulus(4'b0010, 1'b0);
    @(negedge clock);
    checkOutput("pulse_start", S_START);
    applyStimulus(4'b0000, 1'b0);
    @(negedge clock);
    checkOutput("pulse_wait_ack", S_START);
    applyStimulus(4'b0000, 1'b1);
    repeat (4) @(negedge clock);
    checkOutput("pulse_on", S_ON);
    repeat (4) @(negedge clock);
    checkOutput("pulse_hold_last", S_ON);
    @(negedge clock);
    checkOutput("pulse_stop", S_STOP);
    @(negedge clock);
    checkOutput("stop_ack_high", S_STOP);
    applyStimulus(4'b0000, 1'b0);
    @(negedge clock);
    checkOutput("pulse_off", S_OFF);
    @(negedge clock);
    checkOutput("off_stays", S_OFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
